// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
// ccff_chain_loader_if: word handshake, chain drive/return and status signals of the loader.
// The slave modport is the loader; the master modport is its environment.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_clk_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, abort, word_data, word_valid, ccff_tail,
    input  word_ready, ccff_head, ccff_clk_en, busy, done, error
  );

  modport slave (
    input  start, abort, word_data, word_valid, ccff_tail,
    output word_ready, ccff_head, ccff_clk_en, busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ccff_chain_loader: shifts a marker then CHAIN_LEN payload bits into a configuration chain
// and checks that the marker emerges at the chain tail after exactly CHAIN_LEN shifts.
module ccff_chain_loader #(
  parameter int                  WORD_W    = 8,
  parameter int                  CHAIN_LEN = 22,
  parameter int                  MARK_LEN  = 8,
  parameter logic [MARK_LEN-1:0] MARKER    = 8'hA5
) (
  input  logic               prog_clk,
  input  logic               prog_reset_n,
  ccff_chain_loader_if.slave bus_if
);
  localparam int NW  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int CW  = $clog2(MARK_LEN + CHAIN_LEN + 1);
  localparam int WCW = $clog2(NW + 1);
  localparam int BW  = $clog2(WORD_W + 1);

  localparam logic [CW-1:0]  MARK_LAST  = CW'(MARK_LEN - 1);
  localparam logic [CW-1:0]  SHIFT_LAST = CW'(MARK_LEN + CHAIN_LEN - 1);
  localparam logic [CW-1:0]  CHAIN_CNT  = CW'(CHAIN_LEN);
  localparam logic [WCW-1:0] NW_CNT     = WCW'(NW);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MARK    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e              state_q,   state_d;
  logic [CW-1:0]       sh_cnt_q,  sh_cnt_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [MARK_LEN-1:0] mark_sr_q, mark_sr_d;
  logic [MARK_LEN-1:0] cmp_sr_q,  cmp_sr_d;
  logic [WORD_W-1:0]   buf_q,     buf_d;
  logic                buf_vld_q, buf_vld_d;
  logic [BW-1:0]       bit_idx_q, bit_idx_d;
  logic [WCW-1:0]      words_q,   words_d;
  logic                head_q,    head_d;
  logic                en_q,      en_d;
  logic                error_q,   error_d;

  logic w_active;
  logic w_last_bit;
  logic w_issue;
  logic w_ready;
  logic w_accept;

  assign w_active   = (state_q == S_MARK) || (state_q == S_PAYLOAD) || (state_q == S_DRAIN);
  // Last bit of the buffered word: either its LSB or the final payload bit of the load.
  assign w_last_bit = (bit_idx_q == BIT_LAST) || (sh_cnt_q == SHIFT_LAST);
  assign w_issue    = (state_q == S_PAYLOAD) && buf_vld_q;
  assign w_ready    = ((state_q == S_MARK) || (state_q == S_PAYLOAD)) && !bus_if.abort &&
                      (words_q != NW_CNT) && (!buf_vld_q || (w_issue && w_last_bit));
  assign w_accept   = w_ready && bus_if.word_valid;

  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    out_cnt_d = out_cnt_q;
    mark_sr_d = mark_sr_q;
    cmp_sr_d  = cmp_sr_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    bit_idx_d = bit_idx_q;
    words_d   = words_q;
    head_d    = head_q;
    en_d      = 1'b0;
    error_d   = error_q;

    // Tail check follows the chain's real shifts, one cycle behind the issue logic.
    if (en_q) begin
      out_cnt_d = out_cnt_q + CW'(1);
      if (out_cnt_q >= CHAIN_CNT) begin
        cmp_sr_d = cmp_sr_q << 1;
        if (bus_if.ccff_tail != cmp_sr_q[MARK_LEN-1]) begin
          error_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus_if.start && !bus_if.abort) begin
          state_d   = S_MARK;
          sh_cnt_d  = '0;
          out_cnt_d = '0;
          mark_sr_d = MARKER;
          cmp_sr_d  = MARKER;
          buf_d     = '0;
          buf_vld_d = 1'b0;
          bit_idx_d = '0;
          words_d   = '0;
          error_d   = 1'b0;
        end
      end
      S_MARK: begin
        head_d    = mark_sr_q[MARK_LEN-1];
        en_d      = 1'b1;
        mark_sr_d = mark_sr_q << 1;
        sh_cnt_d  = sh_cnt_q + CW'(1);
        if (sh_cnt_q == MARK_LAST) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (buf_vld_q) begin
          head_d    = buf_q[WORD_W-1];
          en_d      = 1'b1;
          buf_d     = buf_q << 1;
          sh_cnt_d  = sh_cnt_q + CW'(1);
          bit_idx_d = bit_idx_q + BW'(1);
          if (w_last_bit) begin
            buf_vld_d = 1'b0;
            bit_idx_d = '0;
          end
          if (sh_cnt_q == SHIFT_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (w_accept) begin
      buf_d     = bus_if.word_data;
      buf_vld_d = 1'b1;
      bit_idx_d = '0;
      words_d   = words_q + WCW'(1);
    end

    if (w_active && bus_if.abort) begin
      state_d   = S_IDLE;
      en_d      = 1'b0;
      buf_vld_d = 1'b0;
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q   <= S_IDLE;
      sh_cnt_q  <= '0;
      out_cnt_q <= '0;
      mark_sr_q <= '0;
      cmp_sr_q  <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      bit_idx_q <= '0;
      words_q   <= '0;
      head_q    <= 1'b0;
      en_q      <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      out_cnt_q <= out_cnt_d;
      mark_sr_q <= mark_sr_d;
      cmp_sr_q  <= cmp_sr_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      bit_idx_q <= bit_idx_d;
      words_q   <= words_d;
      head_q    <= head_d;
      en_q      <= en_d;
      error_q   <= error_d;
    end
  end

  assign bus_if.word_ready  = w_ready;
  assign bus_if.ccff_head   = head_q;
  assign bus_if.ccff_clk_en = en_q;
  assign bus_if.busy        = w_active;
  assign bus_if.done        = (state_q == S_DONE);
  assign bus_if.error       = error_q;
endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// Scoreboard bench for ccff_chain_loader: random bitstream words, a modelled chain of
// selectable length, and expected bit streams / load results derived from the load rules.
module tb_ccff_chain_loader;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 22;
  localparam int MARK_LEN  = 8;
  localparam int NW        = 3;
  localparam int NBITS     = MARK_LEN + CHAIN_LEN;

  typedef struct {
    logic        err;
    logic [21:0] chain;
    logic [21:0] mask;
    int          done_cyc;
    int          n_en;
  } result_t;

  logic prog_clk     = 1'b0;
  logic prog_reset_n = 1'b0;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) bus_if ();

  ccff_chain_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .MARK_LEN (MARK_LEN),
    .MARKER   (8'hA5)
  ) dut (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .bus_if      (bus_if)
  );

  always #5 prog_clk = ~prog_clk;

  logic        exp_bits[$];
  result_t     exp_res[$];
  int          n_vec     = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          start_cyc = 0;
  int          en_cnt    = 0;
  logic [21:0] chain_q   = '0;
  logic [4:0]  tail_idx  = 5'd21;
  logic [7:0]  marker_v  = 8'hA5;
  logic [7:0]  ld_w [NW];
  int          ld_av[NW];

  // Behavioural chain: shifts ccff_head in whenever the gated clock is enabled.
  assign bus_if.ccff_tail = chain_q[tail_idx];
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (bus_if.ccff_clk_en) chain_q <= {chain_q[20:0], bus_if.ccff_head};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops one expected bit per enabled chain cycle, one result per done rise.
  initial begin
    logic    done_prev;
    logic    b;
    result_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (bus_if.ccff_clk_en) begin
        en_cnt++;
        if (exp_bits.size() == 0) fail_now("head_unexpected");
        else begin
          b = exp_bits.pop_front();
          check("head_bit", bus_if.ccff_head, b);
        end
      end
      if (bus_if.done && !done_prev) begin
        if (exp_res.size() == 0) fail_now("done_unexpected");
        else begin
          r = exp_res.pop_front();
          check("error_at_done", bus_if.error, r.err);
          check("chain_contents", chain_q & r.mask, r.chain);
          check("done_cycle", cyc - start_cyc, r.done_cyc);
          check("enabled_cycles", en_cnt, r.n_en);
        end
      end
      done_prev = bus_if.done;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  bus_if.busy, 0);
    check({tag, "_done"},  bus_if.done, 0);
    check({tag, "_error"}, bus_if.error, 0);
    check({tag, "_clken"}, bus_if.ccff_clk_en, 0);
    check({tag, "_head"},  bus_if.ccff_head, 0);
    check({tag, "_ready"}, bus_if.word_ready, 0);
  endtask

  // One load: words in ld_w, word i offered from cycle ld_av[i] after the start edge.
  task automatic run_load(input int chain_len, input int start_k, input int abort_k,
                          input int reset_k, input bit offer_extra);
    logic    s[NBITS];
    int      nexp, nxt, f, nb, wi;
    bit      seen_extra, finished;
    result_t r;
    for (int i = 0; i < NBITS; i++) begin
      if (i < MARK_LEN) s[i] = marker_v[MARK_LEN-1-i];
      else              s[i] = ld_w[(i-MARK_LEN)/WORD_W][WORD_W-1-((i-MARK_LEN)%WORD_W)];
    end
    nexp = (abort_k >= 0) ? abort_k : (reset_k >= 0) ? reset_k - 1 : NBITS;
    for (int i = 0; i < nexp; i++) exp_bits.push_back(s[i]);
    if (abort_k < 0 && reset_k < 0) begin
      r.err = 1'b0;
      for (int n = CHAIN_LEN; n < NBITS; n++)
        if (s[n-chain_len] != s[n-CHAIN_LEN]) r.err = 1'b1;
      r.chain = '0;
      r.mask  = '0;
      for (int k = 0; k < chain_len; k++) begin
        r.chain[k] = s[NBITS-1-k];
        r.mask[k]  = 1'b1;
      end
      nxt = MARK_LEN;
      for (int i = 0; i < NW; i++) begin
        nb  = (CHAIN_LEN - i*WORD_W < WORD_W) ? CHAIN_LEN - i*WORD_W : WORD_W;
        f   = (ld_av[i] + 1 > nxt) ? ld_av[i] + 1 : nxt;
        nxt = f + nb;
      end
      r.done_cyc = nxt + 1;
      r.n_en     = NBITS;
      exp_res.push_back(r);
    end

    tail_idx = 5'(chain_len - 1);
    @(posedge prog_clk); #1;
    bus_if.start = 1'b1;
    @(posedge prog_clk); #1;
    bus_if.start = 1'b0;
    start_cyc    = cyc;
    en_cnt       = 0;
    wi           = 0;
    seen_extra   = 1'b0;
    finished     = 1'b0;
    for (int k = 0; k < 200 && !finished; k++) begin
      if (k == reset_k) begin
        prog_reset_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        bus_if.word_valid = 1'b0;
        @(posedge prog_clk); #1;
        prog_reset_n = 1'b1;
        finished = 1'b1;
      end else begin
        bus_if.start      = (k == start_k);
        bus_if.abort      = (k == abort_k);
        bus_if.word_valid = (wi < NW + int'(offer_extra)) && (k >= ((wi < NW) ? ld_av[wi] : 0));
        bus_if.word_data  = (wi < NW) ? ld_w[wi] : 8'($urandom);
        @(negedge prog_clk);
        if (wi == NW && bus_if.word_valid && !seen_extra) begin
          check("ready_after_nw", bus_if.word_ready, 0);
          seen_extra = 1'b1;
        end
        if (bus_if.word_valid && bus_if.word_ready) wi++;
        if (abort_k >= 0 && k == abort_k + 1) begin
          check("abort_busy",  bus_if.busy, 0);
          check("abort_done",  bus_if.done, 0);
          check("abort_clken", bus_if.ccff_clk_en, 0);
          finished = 1'b1;
        end else if (bus_if.done) begin
          finished = 1'b1;
        end else begin
          @(posedge prog_clk); #1;
        end
      end
    end
    if (!finished) fail_now("load_timeout");
    bus_if.start      = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.word_valid = 1'b0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < NW; i++) ld_w[i] = 8'($urandom);
  endtask

  initial begin
    bus_if.start      = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.word_valid = 1'b0;
    bus_if.word_data  = '0;
    ld_w  = '{8'h3C, 8'hF0, 8'h81};
    ld_av = '{0, 0, 0};
    repeat (3) @(posedge prog_clk);
    #1;
    check_idle_outputs("reset");
    prog_reset_n = 1'b1;

    // Nominal load with a start pulse during payload that must be ignored.
    run_load(22, 15, -1, -1, 1'b0);
    // Second word held back: five stall cycles.
    ld_av = '{0, 20, 0};
    run_load(22, -1, -1, -1, 1'b0);
    // Chain one flop short: marker arrives early; extra word must not be taken.
    ld_av = '{0, 0, 0};
    run_load(21, -1, -1, -1, 1'b1);
    // Abort mid-payload, then a clean reload.
    rand_words();
    run_load(22, -1, 12, -1, 1'b0);
    rand_words();
    run_load(22, -1, -1, -1, 1'b0);
    // Reset mid-marker, then a clean reload.
    rand_words();
    run_load(22, -1, -1, 4, 1'b0);
    rand_words();
    run_load(22, -1, -1, -1, 1'b0);

    // Reset, start and abort together from DONE: reset dominates.
    @(posedge prog_clk); #1;
    prog_reset_n = 1'b0;
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    #1;
    check("rsa_done", bus_if.done, 0);
    @(posedge prog_clk); #1;
    check("rsa_busy",  bus_if.busy, 0);
    check("rsa_clken", bus_if.ccff_clk_en, 0);
    prog_reset_n = 1'b1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    @(posedge prog_clk); #1;
    check("rsa_after_busy", bus_if.busy, 0);

    for (int t = 0; t < 6; t++) begin
      rand_words();
      ld_av[0] = int'($urandom_range(0, 10));
      ld_av[1] = int'($urandom_range(0, 30));
      ld_av[2] = int'($urandom_range(0, 40));
      run_load(($urandom_range(0, 3) == 0) ? 21 : 22, -1, -1, -1, 1'(t % 2));
    end

    repeat (3) @(posedge prog_clk);
    #1;
    check("sb_bits_left", exp_bits.size(), 0);
    check("sb_results_left", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
